// File: rtl/mem_arbiter.sv
// Read-port arbiter in front of the SoC RAM. It merges fetch and load reads onto the single
// RAM read port, routes and byte-aligns the responses, and passes stores straight through.
module mem_arbiter #(
    parameter logic FIRST_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_req_valid_i,
    output logic        if_req_ready_o,
    input  logic [31:0] if_req_addr_i,
    output logic        if_res_valid_o,
    output logic [31:0] if_res_data_o,

    input  logic        ld_req_valid_i,
    output logic        ld_req_ready_o,
    input  logic [31:0] ld_req_addr_i,
    output logic        ld_res_valid_o,
    output logic [31:0] ld_res_data_o,

    input  logic        st_req_valid_i,
    input  logic [31:0] st_req_addr_i,
    input  logic [31:0] st_req_data_i,
    input  logic [3:0]  st_req_mask_i,
    output logic        st_res_valid_o,

    output logic        ram_read_req_valid_o,
    output logic [31:0] ram_read_req_addr_o,
    input  logic        ram_read_res_valid_i,
    input  logic [31:0] ram_read_res_data_i,

    output logic        ram_write_req_valid_o,
    output logic [31:0] ram_write_req_addr_o,
    output logic [31:0] ram_write_req_data_o,
    output logic [3:0]  ram_write_req_mask_o,
    input  logic        ram_write_res_valid_i
);

    logic        pend;
    logic        owner;
    logic [1:0]  off;
    logic        last;
    logic        st_pend;
    logic [31:0] addr_q;

    logic        if_blk;
    logic        ld_blk;
    logic        if_elig;
    logic        ld_elig;
    logic        grant;
    logic        win_ld;
    logic [31:0] win_addr;
    logic        rsp;
    logic [31:0] shifted;

    // A read to the word being written this cycle would see stale data, so it waits a cycle.
    always_comb begin
        if_blk  = st_req_valid_i && (if_req_addr_i[31:2] == st_req_addr_i[31:2]);
        ld_blk  = st_req_valid_i && (ld_req_addr_i[31:2] == st_req_addr_i[31:2]);
        if_elig = if_req_valid_i && !if_blk && !rst_i;
        ld_elig = ld_req_valid_i && !ld_blk && !rst_i;
        grant   = if_elig || ld_elig;
        if (if_elig && ld_elig) begin
            win_ld = ~last;
        end else begin
            win_ld = ld_elig;
        end
        win_addr = win_ld ? ld_req_addr_i : if_req_addr_i;
    end

    assign if_req_ready_o       = grant && !win_ld;
    assign ld_req_ready_o       = grant && win_ld;
    assign ram_read_req_valid_o = grant;
    assign ram_read_req_addr_o  = grant ? {win_addr[31:2], 2'b00} : addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend    <= 1'b0;
            owner   <= 1'b0;
            off     <= 2'b00;
            last    <= ~FIRST_PRIO;
            st_pend <= 1'b0;
            addr_q  <= 32'h0;
        end else begin
            pend    <= grant;
            st_pend <= st_req_valid_i;
            if (grant) begin
                owner  <= win_ld;
                off    <= win_addr[1:0];
                last   <= win_ld;
                addr_q <= {win_addr[31:2], 2'b00};
            end
        end
    end

    // Responses are gated by reset too, so a reply to a pre-reset request never escapes.
    assign rsp     = pend && ram_read_res_valid_i && !rst_i;
    assign shifted = ram_read_res_data_i >> {off, 3'b000};

    assign if_res_valid_o = rsp && !owner;
    assign ld_res_valid_o = rsp && owner;
    assign if_res_data_o  = (rsp && !owner) ? shifted : 32'h0;
    assign ld_res_data_o  = (rsp && owner)  ? shifted : 32'h0;

    assign ram_write_req_valid_o = st_req_valid_i;
    assign ram_write_req_addr_o  = st_req_addr_i;
    assign ram_write_req_data_o  = st_req_data_i;
    assign ram_write_req_mask_o  = st_req_mask_i;
    assign st_res_valid_o        = ram_write_res_valid_i && st_pend && !rst_i;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Upstream neighbour of the SoC RAM.
- Arbitrates the core's instruction-fetch read port and load read port onto the RAM's single read port, and passes the store port through to the RAM write port.
- Routes each one-cycle-latency read response back to its owner and performs sub-word byte alignment itself. RAM read addresses are always issued word-aligned, so the RAM's own shift is always zero and back-to-back reads are safe.
- Stalls a read that targets a word being written in the same cycle.

Parameters:
FIRST_PRIO, 0, requester that wins the first conflict after reset (0 = fetch, 1 = load)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
if_req_valid_i  input  1  fetch read request
if_req_ready_o  output  1  fetch request accepted this cycle
if_req_addr_i  input  32  fetch byte address
if_res_valid_o  output  1  fetch response valid
if_res_data_o  output  32  fetch data, byte-aligned
ld_req_valid_i  input  1  load read request
ld_req_ready_o  output  1  load request accepted this cycle
ld_req_addr_i  input  32  load byte address
ld_res_valid_o  output  1  load response valid
ld_res_data_o  output  32  load data, byte-aligned
st_req_valid_i  input  1  store request (always accepted)
st_req_addr_i  input  32  store byte address
st_req_data_i  input  32  store data, LSB-aligned
st_req_mask_i  input  4  store byte mask, LSB-aligned
st_res_valid_o  output  1  store response
ram_read_req_valid_o  output  1  to RAM read_req_valid
ram_read_req_addr_o  output  32  to RAM read_req_addr, bits[1:0] always 0
ram_read_res_valid_i  input  1  from RAM read_res_valid
ram_read_res_data_i  input  32  from RAM read_res_data
ram_write_req_valid_o  output  1  to RAM write_req_valid
ram_write_req_addr_o  output  32  to RAM write_req_addr
ram_write_req_data_o  output  32  to RAM write_req_data
ram_write_req_mask_o  output  4  to RAM write_req_mask
ram_write_res_valid_i  input  1  from RAM write_res_valid

Behaviour:
- State registers:
  - pend (1b): response outstanding.
  - owner (1b): 0 = fetch, 1 = load.
  - off (2b): byte offset of the outstanding request.
  - last (1b): last winner.
  - All reset to 0, except last, which resets to the inverse of FIRST_PRIO.
- Eligibility (combinational):
  - A read is eligible when its valid is high and not blocked.
  - Blocked: st_req_valid_i && req_addr[31:2] == st_req_addr_i[31:2]. A same-cycle read would return stale data, so it waits one cycle.
- Grant:
  - Only one eligible requester: it wins.
  - Both eligible: the one that is not `last` wins (round-robin).
  - ready_o is high only for the winner. A requester is never granted in the cycle rst_i is high.
- Issue, same cycle as grant:
  - ram_read_req_valid_o = 1.
  - ram_read_req_addr_o = {winner_addr[31:2], 2'b00}.
  - On the next edge: pend <= 1, owner <= winner, off <= winner_addr[1:0], last <= winner.
  - With no grant: pend <= 0, and ram_read_req_addr_o holds its previous value (registered mux, not X).
- Response, exactly 1 cycle after grant:
  - When pend && ram_read_res_valid_i, raise owner's res_valid_o for one cycle.
  - res_data = ram_read_res_data_i >> (8*off).
  - Non-owner res_valid_o = 0. Non-owner res_data_o = 0.
- Back-to-back: a new grant may occur in the response cycle of the previous one; throughput is 1 read/cycle.
- Responses carry no backpressure; requesters must sink them.
- Spurious ram_read_res_valid_i with pend = 0 (e.g. first cycle after reset, since the RAM itself is unreset) is ignored.
- Stores:
  - ram_write_* = st_req_* combinationally; no alignment by arbiter (the RAM shifts).
  - st_res_valid_o = ram_write_res_valid_i, gated by a 1-bit st_pend register, which is set on st_req_valid_i and cleared otherwise.
- Reset mid-operation:
  - rst_i high clears pend and st_pend; all res_valid_o = 0 that cycle and the next.
  - A response to a pre-reset request is dropped.
- Misaligned addresses are not checked; the high bytes of the shifted data are zero-filled.

Test Plan:
- Reset → FIRST_PRIO = 0:
  - All res_valid_o = 0.
  - Inject ram_read_res_valid_i = 1 the next cycle with no request → no response.
- Solo fetch:
  - Fetch to 0x104, RAM word 0xDEADBEEF → ram_read_req_addr_o = 0x104.
  - if_res_valid_o one cycle later with data 0xDEADBEEF; ld_res_valid_o stays 0.
- Load at byte offset 2:
  - Load to 0x10A, word 0x11223344 → ram addr 0x108.
  - ld_res_data_o = 0x00001122.
- Round-robin under conflict:
  - Both valid for 4 cycles, FIRST_PRIO = 0 → grants alternate if, ld, if, ld.
  - 4 responses routed correctly, back-to-back, no idle cycles.
- Store hazard:
  - Store 0xAABBCCDD mask 0xF to 0x200 with a same-cycle load to 0x200 → ld_req_ready_o = 0.
  - Next cycle the load is granted and returns 0xAABBCCDD.
  - st_res_valid_o follows one cycle after the store.
- Reset mid-flight:
  - Grant a fetch, assert rst_i in the response cycle → if_res_valid_o stays 0.
  - After reset deasserts, a new fetch completes normally.
